full_st0_act: RTL and testbench
===============================

// Module: full_st0_act
// PURPOSE
//  ReLU activation stage between full_st0 and full_st1.
//  Forward: takes the stage_0_data_out stream, emits relu(x) as stage_1_data and records one
//   derivative-mask bit per element.
//  Backward: gates the stage_1 error stream with the recorded mask (err * relu'(x)) and
//   returns it to full_st0 as stage_0_error.
//  Two mask banks (ping-pong) let vector k+1 go forward while the error for vector k returns.
// PARAMETERS
//  VEC_LEN   32  elements per vector; the element index wraps at VEC_LEN-1
//  IDX_W     5   index width, = $clog2(VEC_LEN)
// PORTS
//  clk                   in   1   clock; every register is on posedge clk
//  reset                 in   1   synchronous, active-low reset
//  train_en              in   1   1: commit mask banks for backprop; 0: inference, no bank commit
//  stage_0_data_out      in   32  float_24_8 forward element from full_st0
//  stage_0_data_out_fst  in   1   first element of a vector
//  stage_0_data_out_vld  in   1   forward input valid
//  stage_0_data_out_rdy  out  1   forward input ready
//  stage_1_data          out  32  float_24_8 relu(x)
//  stage_1_data_fst      out  1   first element of the output vector
//  stage_1_data_vld      out  1   forward output valid
//  stage_1_data_rdy      in   1   forward output ready
//  stage_1_error_out     in   32  float_24_8 error from full_st1
//  stage_1_error_out_fst in   1   first element of the error vector
//  stage_1_error_out_vld in   1   error input valid
//  stage_1_error_out_rdy out  1   error input ready
//  stage_0_error         out  32  float_24_8 gated error to full_st0
//  stage_0_error_fst     out  1   first element of the gated error vector
//  stage_0_error_vld     out  1   error output valid
//  stage_0_error_rdy     in   1   error output ready
//  seq_err               out  1   sticky flag: fst seen while the index counter != 0
// BEHAVIOUR
//  Reset (reset==0 at a posedge): all *_vld=0; seq_err=0; both indices=0; wb=rb=0; bank_cnt=0;
//   data outputs=0. Data in flight is discarded, including mid-vector.
//  Handshake: transfer when vld&rdy. vld must not depend on rdy. Data and fst stay stable while
//   vld&!rdy.
//  Forward path:
//   - 2-entry skid slice; latency 1 cycle from accept to stage_1_data_vld; 1 element/cycle
//     when unstalled.
//   - relu(x): x[31]==1 or x[30:0]==0 -> 32'h0 (negative zero also maps to +0); otherwise x.
//   - mask_bit = ~x[31] & |x[30:0]; written to mask[wb][widx] on accept.
//   - widx: fst -> 0; otherwise +1; wraps VEC_LEN-1 -> 0.
//   - Accepting element VEC_LEN-1 with train_en=1 commits the bank: wb^=1, bank_cnt+=1.
//   - stage_0_data_out_rdy = slice_space & ~(train_en & bank_cnt==2 & widx==0).
//     A new vector cannot start while both banks hold uncollected masks.
//  Error path:
//   - stage_1_error_out_rdy = slice_space & (bank_cnt!=0); errors stall until a mask is committed.
//   - Output = mask[rb][ridx] ? err : 32'h0. Latency 1 cycle, 2-entry skid slice.
//   - ridx follows the same fst/wrap rules as widx.
//   - Accepting element VEC_LEN-1 releases the bank: rb^=1, bank_cnt-=1.
//  Simultaneous commit and release in one cycle: bank_cnt unchanged, wb and rb both toggle.
//  fst with idx!=0 (either path): seq_err<=1; idx restarts at 0; bank is not committed/released.
//  fst is forwarded unchanged through both slices.
//  train_en=0: no commit, bank_cnt frozen, forward never stalls on banks. Change train_en only
//   between vectors (widx==0).
//  Mask storage: 2*VEC_LEN flops; read is combinational into the error slice.
// STRUCTURE
//  Shared package (types.v):
//   - float_24_8 typedef
//   - FLOAT_ZERO=32'h0
//   - function f24_relu()
//   - function f24_is_pos()
//  Sub-module full_st0_act_slice: 2-entry valid/ready skid buffer, WIDTH parameter
//   (32 data + 1 fst). Instantiated twice, once for forward and once for error.
//  Top level holds: the index counters, the bank FSM (bank_cnt 0/1/2, wb, rb), the mask array,
//   and seq_err.
// TESTING (bench overrides VEC_LEN=4, IDX_W=2)
//  1 Forward: fwd [3F800000,C0000000,00000000,80000000], train_en=1
//    -> out [3F800000,0,0,0], fst on element 0, bank_cnt=1.
//    Then errors 4x 40400000 -> stage_0_error [40400000,0,0,0], bank_cnt=0.
//  2 Back-pressure: stage_1_data_rdy=0 for 5 cycles mid-vector
//    -> no loss or duplication; input rdy drops once 2 entries are held; order preserved.
//  3 Two full vectors with no errors -> third vector fst held with stage_0_data_out_rdy=0.
//    First error vector completes -> rdy=1 on the next cycle.
//  4 fst at widx=2 -> seq_err=1 and stays 1; new vector masks start at index 0.
//  5 Simultaneous: last fwd element and last error element accepted in the same cycle
//    -> bank_cnt unchanged; wb and rb both toggle.
//  6 reset=0 for 1 cycle mid-vector -> next cycle all vld=0, bank_cnt=0, seq_err=0;
//    a following clean vector passes.

Source files
------------

// File: rtl/full_st0_act_pkg.sv
// full_st0_act_pkg: float_24_8 type, zero constant and ReLU helpers shared by the activation stage
package full_st0_act_pkg;
    typedef logic [31:0] float_24_8;
    localparam float_24_8 FLOAT_ZERO = 32'h0;
    // strictly positive: sign clear and not a zero encoding
    function automatic logic f24_is_pos(input float_24_8 x);
        return ~x[31] & (|x[30:0]);
    endfunction
    // negative values and both zeros map to +0
    function automatic float_24_8 f24_relu(input float_24_8 x);
        return f24_is_pos(x) ? x : FLOAT_ZERO;
    endfunction
endpackage

// File: rtl/full_st0_act_slice.sv
// full_st0_act_slice: 2-entry valid/ready skid buffer, 1-cycle latency, full throughput
//  clk, reset (sync, active-low)
//  in_data/in_vld/in_rdy    upstream side; in_rdy is high while the skid entry is free
//  out_data/out_vld/out_rdy downstream side; registered outputs
module full_st0_act_slice #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_vld,
    input  logic             out_rdy
);
    logic [WIDTH-1:0] sk_data;
    logic             sk_vld;
    assign in_rdy = ~sk_vld;
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data <= '0;
            out_vld  <= 1'b0;
            sk_data  <= '0;
            sk_vld   <= 1'b0;
        end else if (out_rdy | ~out_vld) begin
            // output register free: refill from the skid entry first, else from the input
            out_vld <= sk_vld | (in_vld & in_rdy);
            if (sk_vld | in_vld)
                out_data <= sk_vld ? sk_data : in_data;
            sk_vld <= 1'b0;
        end else if (in_vld & in_rdy) begin
            sk_data <= in_data;
            sk_vld  <= 1'b1;
        end
    end
endmodule

// File: rtl/full_st0_act.sv
// full_st0_act: ReLU stage with ping-pong derivative-mask banks for backprop error gating
//  clk, reset (sync, active-low), train_en (1: commit mask banks)
//  stage_0_data_out*  forward input from full_st0      stage_1_data*   relu(x) to full_st1
//  stage_1_error_out* error input from full_st1        stage_0_error*  masked error to full_st0
//  seq_err            sticky: fst arrived while an index counter was mid-vector
module full_st0_act
    import full_st0_act_pkg::*;
#(
    parameter int VEC_LEN = 32,
    parameter int IDX_W   = 5
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      train_en,
    input  float_24_8 stage_0_data_out,
    input  logic      stage_0_data_out_fst,
    input  logic      stage_0_data_out_vld,
    output logic      stage_0_data_out_rdy,
    output float_24_8 stage_1_data,
    output logic      stage_1_data_fst,
    output logic      stage_1_data_vld,
    input  logic      stage_1_data_rdy,
    input  float_24_8 stage_1_error_out,
    input  logic      stage_1_error_out_fst,
    input  logic      stage_1_error_out_vld,
    output logic      stage_1_error_out_rdy,
    output float_24_8 stage_0_error,
    output logic      stage_0_error_fst,
    output logic      stage_0_error_vld,
    input  logic      stage_0_error_rdy,
    output logic      seq_err
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(VEC_LEN - 1);
    logic [IDX_W-1:0]   widx, ridx, wi, ri;
    logic [VEC_LEN-1:0] mask [2];
    logic [1:0]         bank_cnt;
    logic               wb, rb;
    logic               fwd_space, err_space, fwd_acc, err_acc, do_commit, do_release;
    float_24_8          err_gated;
    // a new vector may not overwrite the write bank while both banks await their errors
    assign stage_0_data_out_rdy  = fwd_space & ~(train_en & (bank_cnt == 2'd2) & (widx == '0));
    assign stage_1_error_out_rdy = err_space & (bank_cnt != 2'd0);
    assign fwd_acc    = stage_0_data_out_vld & stage_0_data_out_rdy;
    assign err_acc    = stage_1_error_out_vld & stage_1_error_out_rdy;
    assign wi         = stage_0_data_out_fst ? '0 : widx;
    assign ri         = stage_1_error_out_fst ? '0 : ridx;
    assign do_commit  = fwd_acc & train_en & (wi == LAST);
    assign do_release = err_acc & (ri == LAST);
    assign err_gated  = mask[rb][ri] ? stage_1_error_out : FLOAT_ZERO;
    always_ff @(posedge clk) begin
        if (!reset) begin
            widx     <= '0;
            ridx     <= '0;
            wb       <= 1'b0;
            rb       <= 1'b0;
            bank_cnt <= 2'd0;
            seq_err  <= 1'b0;
            mask     <= '{default: '0};
        end else begin
            if (fwd_acc) begin
                mask[wb][wi] <= f24_is_pos(stage_0_data_out);
                widx         <= (wi == LAST) ? '0 : wi + 1'b1;
            end
            if (err_acc)
                ridx <= (ri == LAST) ? '0 : ri + 1'b1;
            if ((fwd_acc & stage_0_data_out_fst & (widx != '0)) |
                (err_acc & stage_1_error_out_fst & (ridx != '0)))
                seq_err <= 1'b1;
            wb       <= wb ^ do_commit;
            rb       <= rb ^ do_release;
            bank_cnt <= bank_cnt + {1'b0, do_commit} - {1'b0, do_release};
        end
    end
    full_st0_act_slice #(.WIDTH(33)) u_fwd (
        .clk      (clk),
        .reset    (reset),
        .in_data  ({stage_0_data_out_fst, f24_relu(stage_0_data_out)}),
        .in_vld   (fwd_acc),
        .in_rdy   (fwd_space),
        .out_data ({stage_1_data_fst, stage_1_data}),
        .out_vld  (stage_1_data_vld),
        .out_rdy  (stage_1_data_rdy)
    );
    full_st0_act_slice #(.WIDTH(33)) u_err (
        .clk      (clk),
        .reset    (reset),
        .in_data  ({stage_1_error_out_fst, err_gated}),
        .in_vld   (err_acc),
        .in_rdy   (err_space),
        .out_data ({stage_0_error_fst, stage_0_error}),
        .out_vld  (stage_0_error_vld),
        .out_rdy  (stage_0_error_rdy)
    );
endmodule

// File: tb/tb_full_st0_act.sv
// tb_full_st0_act: table-driven vectors with scoreboard queues for both streams
module tb_full_st0_act;
    logic        clk = 1'b0;
    logic        reset, train_en;
    logic [31:0] stage_0_data_out, stage_1_data, stage_1_error_out, stage_0_error;
    logic        stage_0_data_out_fst, stage_0_data_out_vld, stage_0_data_out_rdy;
    logic        stage_1_data_fst, stage_1_data_vld, stage_1_data_rdy;
    logic        stage_1_error_out_fst, stage_1_error_out_vld, stage_1_error_out_rdy;
    logic        stage_0_error_fst, stage_0_error_vld, stage_0_error_rdy;
    logic        seq_err;
    int          checks = 0;
    int          errors = 0;
    logic [32:0] fwd_q[$];
    logic [32:0] err_q[$];

    typedef struct {
        logic [31:0] x;
        logic        fst;
        logic [31:0] y;
        logic        m;
    } vec_t;
    vec_t tv[16];

    always #5 clk = ~clk;

    full_st0_act #(.VEC_LEN(4), .IDX_W(2)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .train_en              (train_en),
        .stage_0_data_out      (stage_0_data_out),
        .stage_0_data_out_fst  (stage_0_data_out_fst),
        .stage_0_data_out_vld  (stage_0_data_out_vld),
        .stage_0_data_out_rdy  (stage_0_data_out_rdy),
        .stage_1_data          (stage_1_data),
        .stage_1_data_fst      (stage_1_data_fst),
        .stage_1_data_vld      (stage_1_data_vld),
        .stage_1_data_rdy      (stage_1_data_rdy),
        .stage_1_error_out     (stage_1_error_out),
        .stage_1_error_out_fst (stage_1_error_out_fst),
        .stage_1_error_out_vld (stage_1_error_out_vld),
        .stage_1_error_out_rdy (stage_1_error_out_rdy),
        .stage_0_error         (stage_0_error),
        .stage_0_error_fst     (stage_0_error_fst),
        .stage_0_error_vld     (stage_0_error_vld),
        .stage_0_error_rdy     (stage_0_error_rdy),
        .seq_err               (seq_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset && stage_1_data_vld && stage_1_data_rdy) begin
            if (fwd_q.size() == 0) chk("fwd_unexpected", {31'b0, stage_1_data_fst, stage_1_data}, 64'h1_0000_0000_0000);
            else chk("fwd_out", {31'b0, stage_1_data_fst, stage_1_data}, {31'b0, fwd_q.pop_front()});
        end
        if (reset && stage_0_error_vld && stage_0_error_rdy) begin
            if (err_q.size() == 0) chk("err_unexpected", {31'b0, stage_0_error_fst, stage_0_error}, 64'h1_0000_0000_0000);
            else chk("err_out", {31'b0, stage_0_error_fst, stage_0_error}, {31'b0, err_q.pop_front()});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic fwd_xfer(input logic [31:0] d, input logic f, input logic [32:0] exp);
        int n = 0;
        stage_0_data_out = d; stage_0_data_out_fst = f; stage_0_data_out_vld = 1'b1;
        @(negedge clk);
        while (!stage_0_data_out_rdy && n < 50) begin n++; @(negedge clk); end
        if (!stage_0_data_out_rdy) chk("fwd_rdy_timeout", 64'd0, 64'd1);
        else fwd_q.push_back(exp);
        @(posedge clk); #1;
        stage_0_data_out_vld = 1'b0;
    endtask

    task automatic err_xfer(input logic [31:0] e, input logic f, input logic [32:0] exp);
        int n = 0;
        stage_1_error_out = e; stage_1_error_out_fst = f; stage_1_error_out_vld = 1'b1;
        @(negedge clk);
        while (!stage_1_error_out_rdy && n < 50) begin n++; @(negedge clk); end
        if (!stage_1_error_out_rdy) chk("err_rdy_timeout", 64'd0, 64'd1);
        else err_q.push_back(exp);
        @(posedge clk); #1;
        stage_1_error_out_vld = 1'b0;
    endtask

    task automatic fwd_i(input int i);
        fwd_xfer(tv[i].x, tv[i].fst, {tv[i].fst, tv[i].y});
    endtask

    task automatic err_i(input int i, input logic [31:0] e);
        err_xfer(e, tv[i].fst, {tv[i].fst, tv[i].m ? e : 32'h0});
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = '{32'h3F800000, 1'b1, 32'h3F800000, 1'b1};
        tv[1]  = '{32'hC0000000, 1'b0, 32'h00000000, 1'b0};
        tv[2]  = '{32'h00000000, 1'b0, 32'h00000000, 1'b0};
        tv[3]  = '{32'h80000000, 1'b0, 32'h00000000, 1'b0};
        tv[4]  = '{32'h7F800000, 1'b1, 32'h7F800000, 1'b1};
        tv[5]  = '{32'h80000001, 1'b0, 32'h00000000, 1'b0};
        tv[6]  = '{32'h00000001, 1'b0, 32'h00000001, 1'b1};
        tv[7]  = '{32'hBF800000, 1'b0, 32'h00000000, 1'b0};
        tv[8]  = '{32'h40000000, 1'b1, 32'h40000000, 1'b1};
        tv[9]  = '{32'h41200000, 1'b0, 32'h41200000, 1'b1};
        tv[10] = '{32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0};
        tv[11] = '{32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1};
        tv[12] = '{32'h00800000, 1'b1, 32'h00800000, 1'b1};
        tv[13] = '{32'h80800000, 1'b0, 32'h00000000, 1'b0};
        tv[14] = '{32'h3F000000, 1'b0, 32'h3F000000, 1'b1};
        tv[15] = '{32'hC1200000, 1'b0, 32'h00000000, 1'b0};
        reset = 1'b0; train_en = 1'b1;
        stage_0_data_out = '0; stage_0_data_out_fst = 1'b0; stage_0_data_out_vld = 1'b0;
        stage_1_error_out = '0; stage_1_error_out_fst = 1'b0; stage_1_error_out_vld = 1'b0;
        stage_1_data_rdy = 1'b1; stage_0_error_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_fwd_vld", {63'b0, stage_1_data_vld}, 64'd0);
        chk("rst_err_vld", {63'b0, stage_0_error_vld}, 64'd0);
        chk("rst_seq_err", {63'b0, seq_err}, 64'd0);
        chk("rst_data", {stage_1_data, stage_0_error}, 64'd0);
        chk("rst_bank", {61'b0, dut.bank_cnt, dut.wb, dut.rb}, 64'd0);
        @(posedge clk); #1;

        // 1: basic forward then error gating
        for (int i = 0; i < 4; i++) fwd_i(i);
        @(negedge clk);
        chk("t1_bank_cnt_commit", {62'b0, dut.bank_cnt}, 64'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) err_i(i, 32'h40400000);
        @(negedge clk);
        chk("t1_bank_cnt_release", {62'b0, dut.bank_cnt}, 64'd0);
        @(posedge clk); #1;

        // 2: output back-pressure mid-vector, inference mode
        train_en = 1'b0;
        stage_1_data_rdy = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk);
                #1 stage_1_data_rdy = 1'b1;
            end
            begin
                fwd_i(4);
                fwd_i(5);
                @(negedge clk);
                chk("t2_rdy_full", {63'b0, stage_0_data_out_rdy}, 64'd0);
                @(posedge clk); #1;
                fwd_i(6);
                fwd_i(7);
            end
        join
        settle();
        chk("t2_bank_frozen", {62'b0, dut.bank_cnt}, 64'd0);

        // 3: both banks full blocks the next vector until one is released
        train_en = 1'b1;
        for (int i = 8; i < 16; i++) fwd_i(i);
        @(negedge clk);
        chk("t3_bank_cnt_two", {62'b0, dut.bank_cnt}, 64'd2);
        @(posedge clk); #1;
        stage_0_data_out = tv[4].x; stage_0_data_out_fst = 1'b1; stage_0_data_out_vld = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_rdy_blocked", {63'b0, stage_0_data_out_rdy}, 64'd0);
        @(posedge clk); #1;
        for (int i = 8; i < 12; i++) err_i(i, 32'hA0000000 + 32'(i));
        @(negedge clk);
        chk("t3_rdy_after_release", {63'b0, stage_0_data_out_rdy}, 64'd1);
        fwd_q.push_back({tv[4].fst, tv[4].y});
        @(posedge clk); #1;
        stage_0_data_out_vld = 1'b0;
        for (int i = 5; i < 8; i++) fwd_i(i);
        for (int i = 12; i < 16; i++) err_i(i, 32'h3E000000 + 32'(i));
        for (int i = 4; i < 8; i++) err_i(i, 32'hC0400000 + 32'(i));
        settle();
        chk("t3_bank_drained", {62'b0, dut.bank_cnt}, 64'd0);

        // 4: fst in mid-vector restarts the index and sets the sticky flag
        fwd_i(0);
        fwd_i(1);
        for (int i = 8; i < 12; i++) fwd_i(i);
        @(negedge clk);
        chk("t4_seq_err", {63'b0, seq_err}, 64'd1);
        chk("t4_bank_cnt", {62'b0, dut.bank_cnt}, 64'd1);
        @(posedge clk); #1;
        for (int i = 8; i < 12; i++) err_i(i, 32'h42000000 + 32'(i));
        settle();
        chk("t4_seq_err_sticky", {63'b0, seq_err}, 64'd1);
        chk("t4_bank_drained", {62'b0, dut.bank_cnt}, 64'd0);

        // 6: reset mid-vector with data held in the forward slice
        stage_1_data_rdy = 1'b0;
        fwd_i(12);
        fwd_i(13);
        reset = 1'b0;
        fwd_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_fwd_vld", {63'b0, stage_1_data_vld}, 64'd0);
        chk("t6_err_vld", {63'b0, stage_0_error_vld}, 64'd0);
        chk("t6_seq_err", {63'b0, seq_err}, 64'd0);
        chk("t6_bank", {61'b0, dut.bank_cnt, dut.wb, dut.rb}, 64'd0);
        @(posedge clk); #1;
        stage_1_data_rdy = 1'b1;
        train_en = 1'b0;
        for (int i = 0; i < 4; i++) fwd_i(i);
        settle();
        chk("t6_clean_bank", {61'b0, dut.bank_cnt, dut.wb, dut.rb}, 64'd0);

        // 5: last forward and last error accepted on the same edge
        train_en = 1'b1;
        for (int i = 4; i < 8; i++) fwd_i(i);
        @(negedge clk);
        chk("t5_before", {61'b0, dut.bank_cnt, dut.wb, dut.rb}, {61'b0, 2'd1, 1'b1, 1'b0});
        @(posedge clk); #1;
        for (int i = 8; i < 11; i++) fwd_i(i);
        for (int i = 4; i < 7; i++) err_i(i, 32'h40A00000 + 32'(i));
        fork
            fwd_i(11);
            err_i(7, 32'h40A00007);
        join
        @(negedge clk);
        chk("t5_after", {61'b0, dut.bank_cnt, dut.wb, dut.rb}, {61'b0, 2'd1, 1'b0, 1'b1});
        @(posedge clk); #1;
        for (int i = 8; i < 12; i++) err_i(i, 32'h41000000 + 32'(i));
        settle();
        chk("t5_drained", {61'b0, dut.bank_cnt, dut.wb, dut.rb}, {61'b0, 2'd0, 1'b0, 1'b0});

        chk("fwd_q_empty", 64'(fwd_q.size()), 64'd0);
        chk("err_q_empty", 64'(err_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
